// File: rtl/johnson_cntr.sv
// johnson_cntr: 8-stage self-correcting Johnson counter, 16-state walking sequence
// ports: clk rising-edge clock; rst async active-low reset to RESET_VALUE;
//        q7..q0 registered stage outputs, q0 loads ~q7 on each advance
module johnson_cntr #(
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic clk,
  input  logic rst,
  output logic q7,
  output logic q6,
  output logic q5,
  output logic q4,
  output logic q3,
  output logic q2,
  output logic q1,
  output logic q0
);
  logic [7:0] s, s_inv, nxt;
  logic legal;
  // legal codes are a run of ones from bit 0 (s & (s+1) == 0) or from bit 7 (same test on ~s)
  always_comb begin
    s_inv = ~s;
    legal = ((s & (s + 8'd1)) == 8'd0) || ((s_inv & (s_inv + 8'd1)) == 8'd0);
    nxt = legal ? {s[6:0], ~s[7]} : 8'h01;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) s <= RESET_VALUE;
    else s <= nxt;
  assign {q7, q6, q5, q4, q3, q2, q1, q0} = s;
endmodule

// File: tb/tb_johnson_cntr.sv
// tb_johnson_cntr: directed checks of sequence, reset, Gray property and self-correction
module tb_johnson_cntr;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_b = 1'b0;
  logic q7, q6, q5, q4, q3, q2, q1, q0;
  logic b7, b6, b5, b4, b3, b2, b1, b0;
  logic [7:0] q, qb, prev;
  int total = 0;
  int bad = 0;
  localparam logic [7:0] SEQ [16] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                      8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
  always #5 clk = ~clk;
  johnson_cntr u_dut (.clk(clk), .rst(rst), .q7(q7), .q6(q6), .q5(q5), .q4(q4),
                      .q3(q3), .q2(q2), .q1(q1), .q0(q0));
  johnson_cntr #(.RESET_VALUE(8'h55)) u_bad (.clk(clk), .rst(rst_b), .q7(b7), .q6(b6), .q5(b5),
                      .q4(b4), .q3(b3), .q2(b2), .q1(b1), .q0(b0));
  assign q = {q7, q6, q5, q4, q3, q2, q1, q0};
  assign qb = {b7, b6, b5, b4, b3, b2, b1, b0};

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (q !== 8'h00) begin bad++; $display("FAIL reset_hold[%0d] got=%h exp=00", i, q); end
      total++;
      if (qb !== 8'h55) begin bad++; $display("FAIL reset_hold_b[%0d] got=%h exp=55", i, qb); end
    end
  endtask

  task automatic test_sequence();
    rst = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      total++;
      if (q !== SEQ[i % 16]) begin bad++; $display("FAIL seq[%0d] got=%h exp=%h", i, q, SEQ[i % 16]); end
    end
  endtask

  task automatic test_period();
    for (int i = 1; i <= 32; i++) begin
      prev = q;
      @(negedge clk);
      total++;
      if (q !== SEQ[i % 16]) begin bad++; $display("FAIL period[%0d] got=%h exp=%h", i, q, SEQ[i % 16]); end
      total++;
      if ($countones(q ^ prev) != 1) begin bad++; $display("FAIL gray[%0d] prev=%h got=%h exp_one_bit_change", i, prev, q); end
    end
  endtask

  task automatic test_mid_reset();
    repeat (5) @(negedge clk);
    total++;
    if (q !== 8'h1F) begin bad++; $display("FAIL pre_reset got=%h exp=1f", q); end
    #2 rst = 1'b0;
    #1;
    total++;
    if (q !== 8'h00) begin bad++; $display("FAIL async_reset got=%h exp=00", q); end
    @(negedge clk);
    total++;
    if (q !== 8'h00) begin bad++; $display("FAIL reset_held got=%h exp=00", q); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (q !== 8'h01) begin bad++; $display("FAIL after_release got=%h exp=01", q); end
  endtask

  task automatic test_correction();
    rst_b = 1'b1;
    @(negedge clk);
    total++;
    if (qb !== 8'h01) begin bad++; $display("FAIL correct got=%h exp=01", qb); end
    @(negedge clk);
    total++;
    if (qb !== 8'h03) begin bad++; $display("FAIL correct_next1 got=%h exp=03", qb); end
    @(negedge clk);
    total++;
    if (qb !== 8'h07) begin bad++; $display("FAIL correct_next2 got=%h exp=07", qb); end
  endtask

  task automatic test_mapping();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (q0 !== 1'b1 || {q7, q6, q5, q4, q3, q2, q1} !== 7'h00) begin
      bad++; $display("FAIL map_rise got=%h exp=01", q);
    end
    repeat (7) @(negedge clk);
    total++;
    if (q !== 8'hFF) begin bad++; $display("FAIL map_ff got=%h exp=ff", q); end
    @(negedge clk);
    total++;
    if (q0 !== 1'b0 || {q7, q6, q5, q4, q3, q2, q1} !== 7'h7F) begin
      bad++; $display("FAIL map_fall got=%h exp=fe", q);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_period();
    test_mid_reset();
    test_correction();
    test_mapping();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
